// File: rtl/frame_capture_ctrl.sv
// Camera-domain capture sequencer: waits for sensor configuration, discards settle frames,
// then gates frame-buffer writes on whole-frame boundaries and keeps frame statistics.
module frame_capture_ctrl #(
    parameter int SETTLE_FRAMES = 2,
    parameter int EXP_PIXELS    = 307200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_done,
    input  logic        vsync,
    input  logic        pixel_valid,
    input  logic [1:0]  mode,
    input  logic        snap_req,
    output logic        wr_en,
    output logic        busy,
    output logic        snap_done,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);

    localparam int             SW          = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_FRAMES);
    localparam logic [18:0]    EXP_CNT     = 19'(EXP_PIXELS);
    localparam logic [18:0]    PIX_MAX     = '1;

    typedef enum logic [2:0] {
        WAIT_CFG,
        SETTLE,
        IDLE,
        ARM,
        CAPTURE
    } state_t;

    state_t        state_reg, state_next;
    logic          vsync_q;
    logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [18:0]   pix_cnt_reg, pix_cnt_next;
    logic          snap_pend_reg, snap_pend_next;
    logic [15:0]   frame_count_reg, frame_count_next;
    logic [7:0]    err_count_reg, err_count_next;
    logic          snap_done_reg, snap_done_next;
    logic          frame_err_reg, frame_err_next;

    logic          vs_rise;
    logic          stop_mode;
    logic [18:0]   pix_end;

    assign vs_rise   = vsync & ~vsync_q;
    assign stop_mode = (mode == 2'b00) || (mode == 2'b11);
    // A pixel coincident with the closing edge still belongs to the ending frame.
    assign pix_end   = (pixel_valid && (pix_cnt_reg != PIX_MAX)) ? pix_cnt_reg + 19'd1 : pix_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= WAIT_CFG;
            vsync_q         <= 1'b1;
            settle_cnt_reg  <= '0;
            pix_cnt_reg     <= '0;
            snap_pend_reg   <= 1'b0;
            frame_count_reg <= '0;
            err_count_reg   <= '0;
            snap_done_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            vsync_q         <= vsync;
            settle_cnt_reg  <= settle_cnt_next;
            pix_cnt_reg     <= pix_cnt_next;
            snap_pend_reg   <= snap_pend_next;
            frame_count_reg <= frame_count_next;
            err_count_reg   <= err_count_next;
            snap_done_reg   <= snap_done_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        settle_cnt_next  = settle_cnt_reg;
        pix_cnt_next     = pix_cnt_reg;
        snap_pend_next   = snap_pend_reg;
        frame_count_next = frame_count_reg;
        err_count_next   = err_count_reg;
        snap_done_next   = 1'b0;
        frame_err_next   = 1'b0;

        // Losing configuration abandons any frame in flight without reporting it.
        if ((state_reg != WAIT_CFG) && !cfg_done) begin
            state_next     = WAIT_CFG;
            snap_pend_next = 1'b0;
        end else begin
            case (state_reg)
                WAIT_CFG: begin
                    if (cfg_done) begin
                        settle_cnt_next = SETTLE_LOAD;
                        state_next      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        state_next = IDLE;
                    end else if (vs_rise) begin
                        settle_cnt_next = settle_cnt_reg - SW'(1);
                    end
                end
                IDLE: begin
                    if (mode == 2'b01) begin
                        state_next = ARM;
                    end else if ((mode == 2'b10) && snap_req) begin
                        state_next     = ARM;
                        snap_pend_next = 1'b1;
                    end
                end
                ARM: begin
                    if (stop_mode) begin
                        state_next     = IDLE;
                        snap_pend_next = 1'b0;
                    end else if (vs_rise) begin
                        pix_cnt_next = '0;
                        state_next   = CAPTURE;
                    end
                end
                CAPTURE: begin
                    pix_cnt_next = pix_end;
                    if (vs_rise) begin
                        frame_count_next = frame_count_reg + 16'd1;
                        if (pix_end != EXP_CNT) begin
                            frame_err_next = 1'b1;
                            if (err_count_reg != 8'hFF) begin
                                err_count_next = err_count_reg + 8'd1;
                            end
                        end
                        if (snap_pend_reg) begin
                            snap_done_next = 1'b1;
                            snap_pend_next = 1'b0;
                            state_next     = IDLE;
                        end else if (mode == 2'b01) begin
                            pix_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = WAIT_CFG;
                end
            endcase
        end
    end

    assign wr_en       = pixel_valid & (state_reg == CAPTURE);
    assign busy        = (state_reg == SETTLE) || (state_reg == ARM) || (state_reg == CAPTURE);
    assign snap_done   = snap_done_reg;
    assign frame_err   = frame_err_reg;
    assign frame_count = frame_count_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: frame-level vector table with a scoreboard for the
// registered end-of-frame results, plus hand sequences for reset and cfg_done loss.
module tb_frame_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst, cfg_done, vsync, pixel_valid, snap_req;
    logic [1:0]  mode;
    logic        wr_en, busy, snap_done, frame_err;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    frame_capture_ctrl #(.SETTLE_FRAMES(2), .EXP_PIXELS(8)) dut (
        .clk(clk), .rst(rst), .cfg_done(cfg_done), .vsync(vsync),
        .pixel_valid(pixel_valid), .mode(mode), .snap_req(snap_req),
        .wr_en(wr_en), .busy(busy), .snap_done(snap_done), .frame_err(frame_err),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   due;
        logic ferr;
        logic sdone;
        int   fcnt;
        int   ecnt;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // One record = a vsync edge, a snap_req slot, then a run of pixels.
    typedef struct {
        logic [1:0] md;
        logic [1:0] md2;
        logic       snap;
        logic       edge_pix;
        int         npix;
        logic       edge_wr;
        int         wr;
        logic       ferr;
        logic       sdone;
        int         fcnt;
        int         ecnt;
        logic       bsy;
    } rec_t;

    logic       cur_rst, cur_cfg;
    logic [1:0] cur_mode;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("frame_err", int'(frame_err), int'(mon_e.ferr));
            chk("snap_done", int'(snap_done), int'(mon_e.sdone));
            chk("frame_count", int'(frame_count), mon_e.fcnt);
            chk("err_count", int'(err_count), mon_e.ecnt);
            $display("frame end @%0d: ferr=%0d sdone=%0d fcnt=%0d ecnt=%0d",
                     cyc, frame_err, snap_done, frame_count, err_count);
        end else if (!rst) begin
            chk("stray_pulse", int'({snap_done, frame_err}), 0);
        end
    end

    task automatic tick(input logic vs, input logic pv, input logic sr);
        @(posedge clk);
        #1;
        rst         = cur_rst;
        cfg_done    = cur_cfg;
        mode        = cur_mode;
        vsync       = vs;
        pixel_valid = pv;
        snap_req    = sr;
        @(negedge clk);
    endtask

    function automatic rec_t mk(input logic [1:0] md, input logic [1:0] md2, input logic snap,
                                input logic edge_pix, input int npix, input logic edge_wr,
                                input int wr, input logic ferr, input logic sdone,
                                input int fcnt, input int ecnt, input logic bsy);
        rec_t r;
        r.md = md; r.md2 = md2; r.snap = snap; r.edge_pix = edge_pix; r.npix = npix;
        r.edge_wr = edge_wr; r.wr = wr; r.ferr = ferr; r.sdone = sdone;
        r.fcnt = fcnt; r.ecnt = ecnt; r.bsy = bsy;
        return r;
    endfunction

    task automatic run_rec(input rec_t r, input string tag);
        exp_t e;
        int   w;
        cur_mode = r.md;
        tick(1'b1, r.edge_pix, 1'b0);
        chk({tag, ".edge_wr"}, int'(wr_en), int'(r.edge_wr));
        e.due = cyc + 1; e.ferr = r.ferr; e.sdone = r.sdone; e.fcnt = r.fcnt; e.ecnt = r.ecnt;
        sb.push_back(e);
        tick(1'b1, 1'b0, r.snap);
        tick(1'b0, 1'b0, 1'b0);
        w = 0;
        for (int i = 0; i < r.npix; i++) begin
            if (i == r.npix / 2) cur_mode = r.md2;
            tick(1'b0, 1'b1, 1'b0);
            w += int'(wr_en);
        end
        chk({tag, ".wr_count"}, w, r.wr);
        tick(1'b0, 1'b0, 1'b0);
        chk({tag, ".busy"}, int'(busy), int'(r.bsy));
        $display("%s: mode=%0d npix=%0d wr=%0d busy=%0d", tag, r.md, r.npix, w, busy);
    endtask

    rec_t tab[15];

    initial begin
        //             md md2 snp ep npx ew wr fe sd fc ec bsy
        tab[0]  = mk(1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1);   // settle edge 1
        tab[1]  = mk(1, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1);   // settle edge 2 -> IDLE -> ARM
        tab[2]  = mk(1, 1, 0, 1, 8, 0, 8, 0, 0, 0, 0, 1);   // armed edge, capture starts
        tab[3]  = mk(1, 1, 0, 0, 8, 0, 8, 0, 0, 1, 0, 1);
        tab[4]  = mk(1, 1, 0, 0, 7, 0, 7, 0, 0, 2, 0, 1);
        tab[5]  = mk(1, 1, 0, 1, 7, 1, 7, 0, 0, 3, 0, 1);   // edge pixel completes 8
        tab[6]  = mk(1, 1, 0, 0, 9, 0, 9, 1, 0, 4, 1, 1);   // 7 pixels -> error
        tab[7]  = mk(1, 0, 0, 0, 7, 0, 7, 1, 0, 5, 2, 1);   // 9 pixels -> error; stop mid-frame
        tab[8]  = mk(0, 0, 1, 1, 8, 1, 0, 0, 0, 6, 2, 0);   // closing edge pixel written
        tab[9]  = mk(2, 2, 1, 0, 8, 0, 0, 0, 0, 6, 2, 1);   // snapshot request
        tab[10] = mk(2, 2, 1, 0, 8, 0, 8, 0, 0, 6, 2, 1);   // snapshot frame; req ignored
        tab[11] = mk(2, 2, 0, 0, 8, 0, 0, 0, 1, 7, 2, 0);   // snap_done
        tab[12] = mk(3, 3, 1, 0, 8, 0, 0, 0, 0, 7, 2, 0);   // mode 11 ignores snap_req
        tab[13] = mk(1, 1, 0, 0, 8, 0, 0, 0, 0, 7, 2, 1);   // IDLE -> ARM
        tab[14] = mk(0, 0, 0, 0, 8, 0, 0, 0, 0, 7, 2, 0);   // ARM aborted by stop

        cur_rst = 1'b1; cur_cfg = 1'b0; cur_mode = 2'b01;
        rst = 1'b1; cfg_done = 1'b0; vsync = 1'b0; pixel_valid = 1'b0; mode = 2'b01; snap_req = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        cur_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(i[1], i[0], 1'b0);
            chk("wait_cfg.wr_en", int'(wr_en), 0);
            chk("wait_cfg.busy", int'(busy), 0);
        end
        chk("reset.frame_count", int'(frame_count), 0);
        chk("reset.err_count", int'(err_count), 0);
        $display("wait_cfg phase: wr_en=%0d busy=%0d", wr_en, busy);

        // Reset wins over cfg_done in the same cycle.
        cur_rst = 1'b1; cur_cfg = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        cur_rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_priority.busy", int'(busy), 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("settle_entry.busy", int'(busy), 1);

        for (int i = 0; i < 15; i++) run_rec(tab[i], $sformatf("tab%0d", i));

        // Error counter saturation: 300 one-pixel frames.
        run_rec(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 7, 2, 1), "sat_arm");
        run_rec(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 7, 2, 1), "sat_start");
        for (int k = 0; k < 300; k++) begin
            logic [1:0] md;
            int         ec;
            md = (k == 299) ? 2'b00 : 2'b01;
            ec = (3 + k > 255) ? 255 : 3 + k;
            run_rec(mk(md, md, 0, 0, 1, 0, (k == 299) ? 0 : 1, 1, 0, 8 + k, ec, k != 299),
                    $sformatf("sat%0d", k));
        end

        // cfg_done lost mid-snapshot.
        run_rec(mk(2, 2, 1, 0, 0, 0, 0, 0, 0, 307, 255, 1), "drop_arm");
        run_rec(mk(2, 2, 0, 0, 0, 0, 0, 0, 0, 307, 255, 1), "drop_capture");
        tick(1'b0, 1'b1, 1'b0);
        chk("drop.wr_before", int'(wr_en), 1);
        cur_cfg = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        chk("drop.wr_same_cycle", int'(wr_en), 1);
        tick(1'b0, 1'b1, 1'b0);
        chk("drop.wr_after", int'(wr_en), 0);
        chk("drop.busy", int'(busy), 0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("drop.frame_count", int'(frame_count), 307);
        chk("drop.err_count", int'(err_count), 255);
        $display("cfg drop: wr_en=%0d busy=%0d fcnt=%0d", wr_en, busy, frame_count);
        cur_cfg = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("restart.busy", int'(busy), 1);
        run_rec(mk(1, 1, 0, 0, 8, 0, 0, 0, 0, 307, 255, 1), "re_settle1");
        run_rec(mk(1, 1, 0, 0, 8, 0, 0, 0, 0, 307, 255, 1), "re_settle2");
        run_rec(mk(1, 1, 0, 0, 8, 0, 8, 0, 0, 307, 255, 1), "re_capture");
        run_rec(mk(0, 0, 0, 0, 8, 0, 0, 0, 0, 308, 255, 0), "re_close");

        tick(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences camera frames into the VGA frame buffer. Sits between the camera pixel reader and the buffer's write port, all in the camera pixel-clock domain. Holds off writes until sensor configuration is done and a settle period has passed. Then gates the buffer write enable on whole-frame boundaries in stop, continuous or single-snapshot mode, and keeps frame and pixel-count statistics.

## Interface
Parameters:
- SETTLE_FRAMES, 2: whole frames discarded after `cfg_done` before the first capture (0 allowed).
- EXP_PIXELS, 307200: expected `pixel_valid` count per frame (640x480).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_done  in  1  level, high once camera register configuration has finished.
- vsync  in  1  camera VSYNC, synchronous to clk; a rising edge marks a frame boundary.
- pixel_valid  in  1  one-cycle strobe per assembled pixel from the pixel reader.
- mode  in  2  00 stop, 01 continuous, 10 snapshot, 11 treated as stop.
- snap_req  in  1  one-cycle pulse that requests one snapshot frame.
- wr_en  out  1  gated frame-buffer write enable.
- busy  out  1  high in SETTLE, ARM or CAPTURE.
- snap_done  out  1  one-cycle pulse when a snapshot frame completes.
- frame_err  out  1  one-cycle pulse when a captured frame's pixel count is not EXP_PIXELS.
- frame_count  out  16  count of completed captured frames; wraps at 65535 to 0.
- err_count  out  8  count of bad frames; saturates at 255.

## Operation
- Boundary event `vs_rise` = vsync & ~vsync_q, where vsync_q is a registered copy of vsync. vsync_q resets to 1, so there is no false edge after reset.
- States:
  - WAIT_CFG (reset state): leave when `cfg_done`=1. Load `settle_cnt`=SETTLE_FRAMES and go to SETTLE.
  - SETTLE: each `vs_rise` decrements `settle_cnt`. When `settle_cnt`=0, go to IDLE; with SETTLE_FRAMES=0 this happens on the next cycle.
  - IDLE:
    - mode=01: go to ARM.
    - mode=10 with `snap_req`: go to ARM and set `snap_pend`.
    - Otherwise stay in IDLE.
  - ARM: on `vs_rise`, clear `pix_cnt` and go to CAPTURE. If mode becomes 00/11 before that, go back to IDLE and clear `snap_pend`.
  - CAPTURE: count `pixel_valid` into the 19-bit `pix_cnt`, saturating at 2^19-1. On `vs_rise` (end of frame):
    - increment `frame_count`;
    - if `pix_cnt`≠EXP_PIXELS, pulse `frame_err` and increment `err_count` (saturating);
    - if `snap_pend`, pulse `snap_done`, clear `snap_pend` and go to IDLE;
    - else if mode=01, clear `pix_cnt` and stay in CAPTURE, so back-to-back frames lose no pixel;
    - else go to IDLE.
- Mode changes during CAPTURE take effect only at the next `vs_rise`. A frame is never truncated.
- If `cfg_done` falls in any state other than WAIT_CFG, go to WAIT_CFG. Clear `snap_pend`; no `snap_done` or `frame_err` is produced.
- `snap_req` is ignored outside IDLE and when mode≠10.
- `wr_en` = `pixel_valid` & (state==CAPTURE). This is combinational, so the write is aligned with the reader's row/col address.
- If `pixel_valid` and `vs_rise` occur in the same CAPTURE cycle, the pixel is written and counted in the ending frame.

## Timing
- Reset values: state WAIT_CFG, `wr_en` 0, `busy` 0, `snap_done` 0, `frame_err` 0, `frame_count` 0, `err_count` 0, `snap_pend` 0, `pix_cnt` 0, `settle_cnt` 0.
- `rst` has priority over every other input in the same cycle.
- `wr_en` has zero-cycle latency from `pixel_valid`.
- State, counters and pulses update on the clk edge where `vs_rise` is true. `snap_done` and `frame_err` are registered and high for exactly the next cycle.
- The first `wr_en` can occur no earlier than the cycle after the (SETTLE_FRAMES+1)-th `vs_rise` following `cfg_done`:
  - SETTLE_FRAMES edges to finish SETTLE;
  - one cycle to pass through IDLE;
  - one `vs_rise` in ARM.

## Test plan
- Reset with cfg_done=0, toggle vsync and pixel_valid → `wr_en` stays 0, state stays WAIT_CFG, all outputs at reset values.
- SETTLE_FRAMES=2, mode=01, cfg_done=1, frames of exactly 307200 pixels → frames 1–2 get no writes; frame 3 is armed; `wr_en` follows `pixel_valid` from frame 4 on; `frame_count` increments per frame; `frame_err` never pulses.
- mode=10, `snap_req` pulse in IDLE → exactly one frame written (307200 `wr_en` strobes), one `snap_done` pulse at the closing `vs_rise`, then IDLE with `busy`=0.
- Frame of 307199 pixels in continuous mode → `frame_err` pulses once, `err_count`=1, `frame_count` still increments; 300 bad frames → `err_count` holds 255.
- Switch mode 01→00 mid-frame → writes continue until that frame's `vs_rise`, then stop; `pixel_valid` coincident with that `vs_rise` is still written.
- Drop cfg_done mid-CAPTURE with `snap_pend` set → next cycle `wr_en`=0, state WAIT_CFG, no `snap_done`; raising cfg_done again restarts SETTLE.
